// File: rtl/serial_word_deser_pkg.sv
// Shared definitions for the serial word deserializer family.
// Provides the counter-width helper and the supported word-width ceiling.
package deser_pkg;

    localparam int MAX_DATA_W = 32;

    function automatic int cnt_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/serial_word_deser_out_stage.sv
// Valid/ready holding register with sticky overrun flag.
// Shared by serial receivers that produce one word per word_done pulse.
module deser_out_stage #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] word,
    input  logic              word_done,
    input  logic              out_ready,
    input  logic              overrun_clr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              overrun
);

    logic accept;
    logic drop;

    always_comb begin
        accept = word_done && (!out_valid || out_ready);
        drop   = word_done && out_valid && !out_ready;
    end

    // A fresh drop outranks a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (accept) begin
                out_data  <= word;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            overrun <= drop || (overrun && !overrun_clr);
        end
    end

endmodule

// File: rtl/serial_word_deser.sv
// Serial-to-parallel word deserializer with frame-sync realignment and valid/ready output.
// Define DESER_PARITY_EN for an even-parity bit per frame and the parity_err output.
module serial_word_deser
    import deser_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b1,
`ifdef DESER_PARITY_EN
    localparam int FRAME_BITS = DATA_W + 1,
`else
    localparam int FRAME_BITS = DATA_W,
`endif
    localparam int CNT_W = cnt_w(FRAME_BITS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              shift_enable,
    input  logic              serial_in,
    input  logic              frame_start,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overrun,
    input  logic              overrun_clr,
`ifdef DESER_PARITY_EN
    output logic              parity_err,
`endif
    output logic [CNT_W-1:0]  bit_count
);

    if (DATA_W < 2 || DATA_W > MAX_DATA_W) begin : g_bad_width
        $error("serial_word_deser: DATA_W out of range");
    end

    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shift_nxt;
    logic [DATA_W-1:0] first_word;
    logic              last_bit;
    logic              word_done;

    always_comb begin
        shift_nxt  = MSB_FIRST ? {shreg[DATA_W-2:0], serial_in}
                               : {serial_in, shreg[DATA_W-1:1]};
        first_word = MSB_FIRST ? DATA_W'(serial_in)
                               : {serial_in, {(DATA_W-1){1'b0}}};
        last_bit   = (bit_count == CNT_W'(FRAME_BITS - 1));
        word_done  = shift_enable && !frame_start && last_bit;
    end

    // frame_start always restarts the count at 1 and never completes a word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg     <= '0;
            bit_count <= '0;
        end else if (shift_enable) begin
            if (frame_start) begin
                shreg     <= first_word;
                bit_count <= CNT_W'(1);
            end else if (last_bit) begin
                bit_count <= '0;
`ifndef DESER_PARITY_EN
                shreg     <= shift_nxt;
`endif
            end else begin
                shreg     <= shift_nxt;
                bit_count <= bit_count + 1'b1;
            end
        end
    end

`ifdef DESER_PARITY_EN
    logic par_acc;

    // Running XOR over the data bits; the parity bit itself is never shifted in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_acc <= 1'b0;
        end else if (shift_enable) begin
            if (frame_start)   par_acc <= serial_in;
            else if (last_bit) par_acc <= 1'b0;
            else               par_acc <= par_acc ^ serial_in;
        end
    end

    logic [DATA_W:0] stage_word;
    logic [DATA_W:0] stage_q;

    assign stage_word = {par_acc ^ serial_in, shreg};
    assign {parity_err, out_data} = stage_q;

    deser_out_stage #(.DATA_W(DATA_W + 1)) u_out (
        .clk         (clk),
        .rst_n       (rst_n),
        .word        (stage_word),
        .word_done   (word_done),
        .out_ready   (out_ready),
        .overrun_clr (overrun_clr),
        .out_data    (stage_q),
        .out_valid   (out_valid),
        .overrun     (overrun)
    );
`else
    deser_out_stage #(.DATA_W(DATA_W)) u_out (
        .clk         (clk),
        .rst_n       (rst_n),
        .word        (shift_nxt),
        .word_done   (word_done),
        .out_ready   (out_ready),
        .overrun_clr (overrun_clr),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .overrun     (overrun)
    );
`endif

endmodule
